// File: rtl/adc_frame_sequencer.sv
// ADC frame sequencer: arms a frame, runs chirps of N down-sampled words separated by idle gaps.
// Optional overrun flag built only when SEQ_OVERRUN_CHECK_EN is defined; err_o is tied low otherwise.
module adc_frame_sequencer #(
  parameter int SAMPLE_CNT_W = 12,
  parameter int CHIRP_CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [15:0]             cfg_psc_i,
  input  logic [SAMPLE_CNT_W-1:0] cfg_samples_i,
  input  logic [CHIRP_CNT_W-1:0]  cfg_chirps_i,
  input  logic [15:0]             cfg_gap_i,
  input  logic                    adc_valid_i,
  input  logic                    sampled_valid_i,
  output logic [15:0]             sample_psc_o,
  output logic                    raw_valid_o,
  output logic                    chirp_start_o,
  output logic                    chirp_done_o,
  output logic                    frame_done_o,
  output logic                    busy_o,
  output logic [CHIRP_CNT_W-1:0]  chirp_idx_o,
  output logic [SAMPLE_CNT_W-1:0] sample_idx_o,
  output logic                    err_o
);

  // state | meaning
  // IDLE  | waiting for start_i; cfg latched on an accepted start
  // ARM   | single cycle; empty frames skip straight to DONE
  // CHIRP | forwarding ADC strobes, counting down-sampled words
  // GAP   | idle cycles between chirps, down-counted
  // DONE  | one-cycle frame_done_o, then IDLE
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_CHIRP, S_GAP, S_DONE} state_t;

  localparam logic [SAMPLE_CNT_W-1:0] SAMPLE_ONE = {{(SAMPLE_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CHIRP_CNT_W-1:0]  CHIRP_ONE  = {{(CHIRP_CNT_W-1){1'b0}}, 1'b1};

  state_t                  state, state_next;
  logic [15:0]             psc_q, gap_q, gap_cnt;
  logic [SAMPLE_CNT_W-1:0] samples_q, sample_idx;
  logic [CHIRP_CNT_W-1:0]  chirps_q, chirp_idx;
  logic                    start_acc, abort_act, chirp_end, last_chirp, enter_done;
  logic                    chirp_start_q, chirp_done_q;

  always_comb begin
    state_next = state;
    start_acc  = 1'b0;
    chirp_end  = 1'b0;
    abort_act  = abort_i && (state != S_IDLE);
    last_chirp = (chirp_idx == (chirps_q - CHIRP_ONE));
    case (state)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          start_acc  = 1'b1;
          state_next = S_ARM;
        end
      end
      S_ARM: begin
        state_next = (samples_q == '0 || chirps_q == '0) ? S_DONE : S_CHIRP;
      end
      S_CHIRP: begin
        if (sampled_valid_i && (sample_idx == (samples_q - SAMPLE_ONE))) begin
          chirp_end  = 1'b1;
          state_next = last_chirp ? S_DONE : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt <= 16'd1) state_next = S_CHIRP;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    // abort beats both a simultaneous chirp end and any pending transition
    if (abort_act) begin
      state_next = S_IDLE;
      chirp_end  = 1'b0;
    end
    enter_done = (state_next == S_DONE) && (state != S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      psc_q         <= 16'd1;
      samples_q     <= '0;
      chirps_q      <= '0;
      gap_q         <= '0;
      sample_idx    <= '0;
      chirp_idx     <= '0;
      gap_cnt       <= '0;
      chirp_start_q <= 1'b0;
      chirp_done_q  <= 1'b0;
    end else begin
      state         <= state_next;
      chirp_start_q <= (state_next == S_CHIRP) && (state != S_CHIRP);
      chirp_done_q  <= chirp_end;

      if (start_acc) begin
        psc_q     <= (cfg_psc_i == 16'd0) ? 16'd1 : cfg_psc_i;
        samples_q <= cfg_samples_i;
        chirps_q  <= cfg_chirps_i;
        gap_q     <= cfg_gap_i;
      end

      if (abort_act || chirp_end) begin
        sample_idx <= '0;
      end else if (state == S_CHIRP && sampled_valid_i) begin
        sample_idx <= sample_idx + SAMPLE_ONE;
      end

      if (abort_act || enter_done) begin
        chirp_idx <= '0;
      end else if (chirp_end && !last_chirp) begin
        chirp_idx <= chirp_idx + CHIRP_ONE;
      end

      if (abort_act) begin
        gap_cnt <= '0;
      end else if (chirp_end && !last_chirp) begin
        gap_cnt <= (gap_q == 16'd0) ? 16'd1 : gap_q;
      end else if (state == S_GAP && gap_cnt != 16'd0) begin
        gap_cnt <= gap_cnt - 16'd1;
      end
    end
  end

`ifdef SEQ_OVERRUN_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (start_acc) begin
      err_q <= 1'b0;
    end else if (sampled_valid_i && state != S_CHIRP) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign sample_psc_o  = psc_q;
  assign raw_valid_o   = adc_valid_i && (state == S_CHIRP) && !abort_i;
  assign chirp_start_o = chirp_start_q;
  assign chirp_done_o  = chirp_done_q;
  assign frame_done_o  = (state == S_DONE) && !abort_i;
  assign busy_o        = (state != S_IDLE);
  assign chirp_idx_o   = chirp_idx;
  assign sample_idx_o  = sample_idx;

endmodule
